// File: rtl/decodificador_display_pkg.sv
// rtl/decodificador_display_pkg.sv - shared tables for the 4-bit link decoder and hex display
// Contents: encoder/decoder nibble mappings, hex->segment patterns,
// segment bit indices a..g and the blank pattern.
package decodificador_display_pkg;

  // Segment bit positions inside the {g,f,e,d,c,b,a} bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Logical (active-high) blank; output polarity is applied at the top
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Encoder mapping data -> code, kept here so both ends of the link share one source
  function automatic logic [3:0] encode_nibble(input logic [3:0] data);
    logic [3:0] code;
    case (data)
      4'h0: code = 4'h5;
      4'h1: code = 4'hA;
      4'h2: code = 4'h1;
      4'h3: code = 4'hE;
      4'h4: code = 4'hB;
      4'h5: code = 4'h6;
      4'h6: code = 4'h4;
      4'h7: code = 4'hC;
      4'h8: code = 4'h9;
      4'h9: code = 4'hF;
      4'hA: code = 4'h3;
      4'hB: code = 4'h7;
      4'hC: code = 4'h0;
      4'hD: code = 4'h2;
      4'hE: code = 4'hD;
      default: code = 4'h8;
    endcase
    return code;
  endfunction

  // Exact inverse of encode_nibble: code -> data
  function automatic logic [3:0] decode_nibble(input logic [3:0] code);
    logic [3:0] data;
    case (code)
      4'h0: data = 4'hC;
      4'h1: data = 4'h2;
      4'h2: data = 4'hD;
      4'h3: data = 4'hA;
      4'h4: data = 4'h6;
      4'h5: data = 4'h0;
      4'h6: data = 4'h5;
      4'h7: data = 4'hB;
      4'h8: data = 4'hF;
      4'h9: data = 4'h8;
      4'hA: data = 4'h1;
      4'hB: data = 4'h4;
      4'hC: data = 4'h7;
      4'hD: data = 4'hE;
      4'hE: data = 4'h3;
      default: data = 4'h9;
    endcase
    return data;
  endfunction

  // Hex digit -> active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/decodificador_display_hex_to_7seg.sv
// rtl/decodificador_display_hex_to_7seg.sv - combinational hex digit to 7-segment pattern
// Ports: i_nibble (digit value), i_valid (slot holds data), o_seg (active-high {g..a}, blank when invalid).
module hex_to_7seg
  import decodificador_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_valid,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_valid) begin
      o_seg = hex_pattern(i_nibble);
    end
  end

endmodule

// File: rtl/decodificador_display.sv
// rtl/decodificador_display.sv - link decoder with nibble history and multiplexed hex display
// Ports: clock, reset (sync, active-high), ready + S3..S0 (incoming code),
// A..D + data_valid (decoded nibble, 1-cycle pulse), seg {g..a}, an (one-hot digit enable).
// Build option DECODIFICADOR_SEG_ACTIVE_LOW_EN inverts seg and an for common-anode displays.
module decodificador_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic              S3,
  input  logic              S2,
  input  logic              S1,
  input  logic              S0,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic              data_valid,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  import decodificador_display_pkg::*;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [DIGITS-1:0] AN_SLOT0 = DIGITS'(1);

`ifdef DECODIFICADOR_SEG_ACTIVE_LOW_EN
  localparam logic [6:0]        SEG_POL_MASK = 7'h7F;
  localparam logic [DIGITS-1:0] AN_POL_MASK  = '1;
`else
  localparam logic [6:0]        SEG_POL_MASK = 7'h00;
  localparam logic [DIGITS-1:0] AN_POL_MASK  = '0;
`endif

  logic [3:0]        r_data;
  logic              r_data_valid;
  logic [3:0]        r_slot_val [DIGITS];
  logic [DIGITS-1:0] r_slot_vld;
  logic [CNT_W-1:0]  r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic [3:0]        w_code;
  logic [3:0]        w_dec;
  logic              w_cnt_tc;
  logic [IDX_W-1:0]  w_idx_next;
  logic [DIGITS-1:0] w_an_next;
  logic [6:0]        w_seg_next;

  assign w_code = {S3, S2, S1, S0};
  assign w_dec  = decode_nibble(w_code);

  always_comb begin
    w_cnt_tc   = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));
    w_idx_next = r_idx;
    if (w_cnt_tc) begin
      w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_an_next = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_an_next[k] = (w_idx_next == IDX_W'(k));
    end
  end

  // an and seg both come from the upcoming index so they switch together.
  // The slot read here is the pre-shift buffer; a capture on this edge
  // only becomes visible on the following edge.
  hex_to_7seg u_hex_to_7seg (
    .i_nibble (r_slot_val[w_idx_next]),
    .i_valid  (r_slot_vld[w_idx_next]),
    .o_seg    (w_seg_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_slot_vld   <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        r_slot_val[k] <= '0;
      end
      r_scan_cnt   <= '0;
      r_idx        <= '0;
      r_seg        <= SEG_BLANK ^ SEG_POL_MASK;
      r_an         <= AN_SLOT0 ^ AN_POL_MASK;
    end else begin
      r_data_valid <= ready;
      if (ready) begin
        r_data <= w_dec;
        for (int k = DIGITS - 1; k > 0; k--) begin
          r_slot_val[k] <= r_slot_val[k-1];
          r_slot_vld[k] <= r_slot_vld[k-1];
        end
        r_slot_val[0] <= w_dec;
        r_slot_vld[0] <= 1'b1;
      end
      r_scan_cnt <= w_cnt_tc ? '0 : r_scan_cnt + 1'b1;
      r_idx      <= w_idx_next;
      r_seg      <= w_seg_next ^ SEG_POL_MASK;
      r_an       <= w_an_next ^ AN_POL_MASK;
    end
  end

  assign {A, B, C, D} = r_data;
  assign data_valid   = r_data_valid;
  assign seg          = r_seg;
  assign an           = r_an;

endmodule

// File: tb/tb_decodificador_display.sv
// tb/tb_decodificador_display.sv - self-checking bench for decodificador_display
module tb_decodificador_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

`ifdef DECODIFICADOR_SEG_ACTIVE_LOW_EN
  localparam logic [6:0]        SEGX = 7'h7F;
  localparam logic [DIGITS-1:0] ANX  = 4'hF;
`else
  localparam logic [6:0]        SEGX = 7'h00;
  localparam logic [DIGITS-1:0] ANX  = 4'h0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b0;
  logic S3 = 1'b0, S2 = 1'b0, S1 = 1'b0, S0 = 1'b0;
  logic A, B, C, D, data_valid;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  decodificador_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .S3(S3), .S2(S2), .S1(S1), .S0(S0),
    .A(A), .B(B), .C(C), .D(D), .data_valid(data_valid),
    .seg(seg), .an(an)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] code;
    logic [3:0] data;
  } vec_t;

  vec_t       vecs [16];
  logic [6:0] HEX  [16];
  logic [3:0] sb [$];
  logic [3:0] hist_val [DIGITS];
  logic       hist_vld [DIGITS];
  int n_cmp = 0;
  int n_bad = 0;
  logic mon_dv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_hist();
    for (int k = 0; k < DIGITS; k++) begin
      hist_val[k] = 4'h0;
      hist_vld[k] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ready = 1'b0;
    clear_hist();
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] code);
    {S3, S2, S1, S0} = code;
    ready = 1'b1;
    if (!reset) begin
      sb.push_back(vecs[code].data);
      for (int k = DIGITS - 1; k > 0; k--) begin
        hist_val[k] = hist_val[k-1];
        hist_vld[k] = hist_vld[k-1];
      end
      hist_val[0] = vecs[code].data;
      hist_vld[0] = 1'b1;
    end
    step();
  endtask

  task automatic idle(input int n);
    ready = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [6:0] exp_seg(input int idx);
    return (hist_vld[idx] ? HEX[hist_val[idx]] : 7'h00) ^ SEGX;
  endfunction

  function automatic int an_idx(input logic [DIGITS-1:0] v);
    int r = 0;
    for (int k = 0; k < DIGITS; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Observes the scan for ncyc cycles: one-hot enable, correct slot pattern,
  // rotation order and dwell time of SCAN_DIV cycles per digit.
  task automatic check_display(input int ncyc);
    logic [DIGITS-1:0] a_prev, a_cur;
    int hold = 0;
    bit seen = 1'b0;
    int idx, pidx;
    a_prev = an ^ ANX;
    pidx   = an_idx(a_prev);
    for (int c = 0; c < ncyc; c++) begin
      step();
      a_cur = an ^ ANX;
      idx   = an_idx(a_cur);
      chk("an_onehot", 32'($onehot(a_cur)), 32'd1);
      chk("seg_slot", 32'(seg), 32'(exp_seg(idx)));
      if (a_cur != a_prev) begin
        if (seen) chk("scan_hold", 32'(hold), 32'(SCAN_DIV));
        chk("scan_order", 32'(idx), 32'((pidx + 1) % DIGITS));
        seen = 1'b1;
        hold = 1;
      end else begin
        hold++;
      end
      a_prev = a_cur;
      pidx   = idx;
    end
  endtask

  // Scoreboard monitor: expected data_valid follows the sampled strobe,
  // and each pulse retires the oldest expected nibble.
  always @(posedge clock) begin
    mon_dv = ready & ~reset;
    #2;
    chk("data_valid", 32'(data_valid), 32'(mon_dv));
    if (data_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        chk("nibble", 32'({A, B, C, D}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{4'h0, 4'hC}, '{4'h1, 4'h2}, '{4'h2, 4'hD}, '{4'h3, 4'hA},
      '{4'h4, 4'h6}, '{4'h5, 4'h0}, '{4'h6, 4'h5}, '{4'h7, 4'hB},
      '{4'h8, 4'hF}, '{4'h9, 4'h8}, '{4'hA, 4'h1}, '{4'hB, 4'h4},
      '{4'hC, 4'h7}, '{4'hD, 4'hE}, '{4'hE, 4'h3}, '{4'hF, 4'h9}
    };
    HEX = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // 1: reset state and idle blank scan
    do_reset(3);
    chk("rst_abcd", 32'({A, B, C, D}), 32'h0);
    chk("rst_an", 32'(an), 32'(4'b0001 ^ ANX));
    chk("rst_seg", 32'(seg), 32'(7'h00 ^ SEGX));
    check_display(20);

    // 2: single code 5 -> data 0, shown on digit 0
    idle(1);
    send(4'h5);
    idle(2);
    check_display(20);

    // 3: all codes back to back
    do_reset(1);
    for (int i = 0; i < 16; i++) send(vecs[i].code);
    idle(2);
    check_display(24);

    // 4: four codes fill the buffer, a fifth shifts it
    do_reset(2);
    send(4'hA); send(4'h2); send(4'hE); send(4'h8);
    idle(2);
    check_display(36);
    send(4'h5);
    idle(2);
    check_display(20);

    // 5: partial buffer and capture coinciding with scan wrap to digit 0
    do_reset(3);                 // last reset edge = R
    send(4'h5);                  // edge R+1
    ready = 1'b0;
    for (int e = 2; e <= 15; e++) begin
      step();
      if (e == 2)  begin chk("p5_an0", 32'(an), 32'(4'b0001 ^ ANX)); chk("p5_seg0", 32'(seg), 32'(7'h3F ^ SEGX)); end
      if (e == 5)  begin chk("p5_an1", 32'(an), 32'(4'b0010 ^ ANX)); chk("p5_seg1", 32'(seg), 32'(7'h00 ^ SEGX)); end
      if (e == 9)  begin chk("p5_an2", 32'(an), 32'(4'b0100 ^ ANX)); chk("p5_seg2", 32'(seg), 32'(7'h00 ^ SEGX)); end
      if (e == 13) begin chk("p5_an3", 32'(an), 32'(4'b1000 ^ ANX)); chk("p5_seg3", 32'(seg), 32'(7'h00 ^ SEGX)); end
    end
    send(4'h8);                  // edge R+16: scan wraps to digit 0 on the same edge
    chk("wrap_an", 32'(an), 32'(4'b0001 ^ ANX));
    chk("wrap_seg_old", 32'(seg), 32'(7'h3F ^ SEGX));
    idle(1);                     // edge R+17
    chk("wrap_seg_new", 32'(seg), 32'(7'h71 ^ SEGX));
    check_display(20);

    // 6: reset mid-scan with a strobed code that must be dropped
    send(4'h3);
    send(4'h7);
    idle(5);
    reset = 1'b1;
    {S3, S2, S1, S0} = 4'b1001;
    ready = 1'b1;
    clear_hist();
    step();
    chk("r6_abcd", 32'({A, B, C, D}), 32'h0);
    chk("r6_an", 32'(an), 32'(4'b0001 ^ ANX));
    chk("r6_seg", 32'(seg), 32'(7'h00 ^ SEGX));
    reset = 1'b0;
    ready = 1'b0;
    check_display(20);

    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
